execute: RTL and testbench

//  Execute/writeback stage sitting directly downstream of fetch. Consumes the decoded

---
 rtl/execute.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_execute.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// Execute/writeback stage: register file, ALU, branch resolution and data-memory handshake.
// Optional retired-instruction counter output instret enabled by defining EXECUTE_INSTRET_EN.
module execute #(
    parameter int XLEN = 32,
    parameter int REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [11:0]     code,
    input  logic            isLoad,
    input  logic            isBranch,
    input  logic            writeEnabled,
    input  logic [31:0]     pcIn,
    output logic [31:0]     pcBranch,
    output logic            originPc,
    output logic            hold,
    output logic            dmemReq,
    output logic            dmemWe,
    output logic [31:0]     dmemAddr,
    output logic [XLEN-1:0] dmemWdata,
    output logic [3:0]      dmemBe,
    input  logic [XLEN-1:0] dmemRdata,
    input  logic            dmemAck
`ifdef EXECUTE_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [XLEN-1:0] regs_q [REGS];

    logic [0:0]      state_q, state_d;
    logic            origin_q, origin_d;
    logic [31:0]     pc_branch_q, pc_branch_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;

    logic            wb_en;
    logic [4:0]      wb_idx;
    logic [XLEN-1:0] wb_val;
    logic            retire;
    logic            accept;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val, mem_addr;

    function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        sa = a;
        alu_op = '0;
        case (f3)
            3'b000: alu_op = alt ? a - b : a + b;
            3'b001: alu_op = a << b[4:0];
            3'b010: alu_op = {{(XLEN-1){1'b0}}, sa < $signed(b)};
            3'b011: alu_op = {{(XLEN-1){1'b0}}, a < b};
            3'b100: alu_op = a ^ b;
            3'b101: begin
                if (alt) alu_op = sa >>> b[4:0];
                else     alu_op = a >> b[4:0];
            end
            3'b110: alu_op = a | b;
            default: alu_op = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            3'b000: branch_taken = (a == b);
            3'b001: branch_taken = (a != b);
            3'b100: branch_taken = ($signed(a) < $signed(b));
            3'b101: branch_taken = ($signed(a) >= $signed(b));
            3'b110: branch_taken = (a < b);
            3'b111: branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << lane;
            2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] v);
        case (f3[1:0])
            2'b00:   store_data = {4{v[7:0]}};
            2'b01:   store_data = {2{v[15:0]}};
            default: store_data = v;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [XLEN-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
            3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
            default: load_ext = rdata;
        endcase
    endfunction

    always_comb begin
        opcode   = code[6:0];
        funct3   = code[9:7];
        rs1_val  = regs_q[rs1];
        rs2_val  = regs_q[rs2];
        mem_addr = rs1_val + imm;
        accept   = writeEnabled & ~origin_q & (state_q == ST_IDLE);

        state_d     = state_q;
        origin_d    = 1'b0;
        pc_branch_d = pc_branch_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ld_rd_d     = ld_rd_q;
        ld_f3_d     = ld_f3_q;
        wb_en       = 1'b0;
        wb_idx      = rd;
        wb_val      = '0;
        retire      = 1'b0;

        if (state_q == ST_MEM_WAIT) begin
            if (dmemAck) begin
                state_d = ST_IDLE;
                retire  = 1'b1;
                if (!we_q) begin
                    wb_en  = 1'b1;
                    wb_idx = ld_rd_q;
                    wb_val = load_ext(ld_f3_q, addr_q[1:0], dmemRdata);
                end
            end
        end else if (accept) begin
            retire = 1'b1;
            // code[11] set marks an undecodable slot; it retires as a NOP
            if (!code[11]) begin
                case (opcode)
                    OP_REG: begin
                        wb_en  = 1'b1;
                        wb_val = alu_op(funct3, code[10], rs1_val, rs2_val);
                    end
                    OP_IMM: begin
                        wb_en  = 1'b1;
                        wb_val = alu_op(funct3, code[10] & (funct3 == 3'b101), rs1_val, imm);
                    end
                    OP_LUI: begin
                        wb_en  = 1'b1;
                        wb_val = imm;
                    end
                    OP_AUIPC: begin
                        wb_en  = 1'b1;
                        wb_val = pcIn + imm;
                    end
                    OP_JAL: if (isBranch) begin
                        wb_en       = 1'b1;
                        wb_val      = pcIn + 32'd4;
                        origin_d    = 1'b1;
                        pc_branch_d = pcIn + imm;
                    end
                    OP_JALR: if (isBranch) begin
                        wb_en       = 1'b1;
                        wb_val      = pcIn + 32'd4;
                        origin_d    = 1'b1;
                        pc_branch_d = mem_addr & ~32'd1;
                    end
                    OP_BRANCH: if (isBranch && branch_taken(funct3, rs1_val, rs2_val)) begin
                        origin_d    = 1'b1;
                        pc_branch_d = pcIn + imm;
                    end
                    OP_LOAD: if (isLoad) begin
                        retire  = 1'b0;
                        state_d = ST_MEM_WAIT;
                        we_d    = 1'b0;
                        addr_d  = mem_addr;
                        be_d    = lane_be(funct3, mem_addr[1:0]);
                        ld_rd_d = rd;
                        ld_f3_d = funct3;
                    end
                    OP_STORE: begin
                        retire  = 1'b0;
                        state_d = ST_MEM_WAIT;
                        we_d    = 1'b1;
                        addr_d  = mem_addr;
                        be_d    = lane_be(funct3, mem_addr[1:0]);
                        wdata_d = store_data(funct3, rs2_val);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            origin_q    <= 1'b0;
            pc_branch_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            ld_rd_q     <= '0;
            ld_f3_q     <= '0;
        end else begin
            state_q     <= state_d;
            origin_q    <= origin_d;
            pc_branch_q <= pc_branch_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ld_rd_q     <= ld_rd_d;
            ld_f3_q     <= ld_f3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
        end else if (wb_en && wb_idx != 5'd0) begin
            regs_q[wb_idx] <= wb_val;
        end
    end

`ifdef EXECUTE_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + {63'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

    assign pcBranch  = pc_branch_q;
    assign originPc  = origin_q;
    assign hold      = (state_q == ST_MEM_WAIT);
    assign dmemReq   = (state_q == ST_MEM_WAIT);
    assign dmemWe    = we_q;
    assign dmemAddr  = addr_q;
    assign dmemWdata = wdata_q;
    assign dmemBe    = be_q;

endmodule

// File: tb/tb_execute.sv
// Bench for execute: instruction-level reference model compared every cycle, plus directed literal checks.
module tb_execute;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPI = 7'h13, OPR = 7'h33;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [11:0] code;
    logic        isLoad, isBranch, writeEnabled;
    logic [31:0] pcIn;
    logic [31:0] pcBranch;
    logic        originPc, hold, dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemBe;
    logic        dmemAck;
`ifdef EXECUTE_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    execute dut (
        .clk(clk), .reset(reset), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .code(code),
        .isLoad(isLoad), .isBranch(isBranch), .writeEnabled(writeEnabled), .pcIn(pcIn),
        .pcBranch(pcBranch), .originPc(originPc), .hold(hold), .dmemReq(dmemReq),
        .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemBe(dmemBe),
        .dmemRdata(dmemRdata), .dmemAck(dmemAck)
`ifdef EXECUTE_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction semantics) ----------------
    logic [31:0] mr [32];
    bit          m_busy, m_origin, m_we;
    logic [31:0] m_pcb, m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    longint unsigned m_instret;

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
        return int'(addr[1:0]) & ~(nbytes(f3) - 1);
    endfunction

    function automatic logic [31:0] m_ldext(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
        int n;
        logic [31:0] v, mask;
        n = nbytes(f3);
        v = rdata >> (8 * lane_off(f3, addr));
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input bit alt);
        int sh;
        sh = int'(b & 32'h1F);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(int'(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic wreg(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) mr[d] = v;
    endtask

    task automatic model_exec(output bit take, output bit mem);
        logic [2:0]  f3;
        logic [31:0] a, b;
        bit cond;
        f3 = code[9:7];
        a = mr[rs1];
        b = mr[rs2];
        take = 0;
        mem = 0;
        cond = 0;
        if (code[11] == 1'b0) begin
            case (code[6:0])
                OPR:   wreg(rd, m_alu(f3, a, b, code[10]));
                OPI:   wreg(rd, m_alu(f3, a, imm, code[10] && f3 == 3'd5));
                LUI:   wreg(rd, imm);
                AUIPC: wreg(rd, pcIn + imm);
                JAL: if (isBranch) begin
                    wreg(rd, pcIn + 4); take = 1; m_pcb = pcIn + imm;
                end
                JALR: if (isBranch) begin
                    wreg(rd, pcIn + 4); take = 1; m_pcb = (a + imm) & ~32'd1;
                end
                BR: if (isBranch) begin
                    case (f3)
                        3'd0: cond = (a == b);
                        3'd1: cond = (a != b);
                        3'd4: cond = int'(a) < int'(b);
                        3'd5: cond = int'(a) >= int'(b);
                        3'd6: cond = a < b;
                        3'd7: cond = a >= b;
                        default: cond = 0;
                    endcase
                    if (cond) begin take = 1; m_pcb = pcIn + imm; end
                end
                LOAD, STORE: if (code[6:0] == STORE || isLoad) begin
                    mem = 1; m_busy = 1; m_we = (code[6:0] == STORE);
                    m_addr = a + imm; m_rd = rd; m_f3 = f3;
                    m_be = 4'(((1 << nbytes(f3)) - 1) << lane_off(f3, m_addr));
                    if (nbytes(f3) == 1)      m_wdata = {4{b[7:0]}};
                    else if (nbytes(f3) == 2) m_wdata = {2{b[15:0]}};
                    else                      m_wdata = b;
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) begin : model
        bit take, mem;
        if (reset) begin
            for (int i = 0; i < 32; i++) mr[i] = '0;
            m_busy = 0; m_origin = 0; m_we = 0; m_pcb = '0; m_addr = '0; m_wdata = '0;
            m_be = '0; m_instret = 0;
        end else begin
            take = 0;
            if (m_busy) begin
                if (dmemAck) begin
                    m_busy = 0;
                    m_instret++;
                    if (!m_we) wreg(m_rd, m_ldext(m_f3, m_addr, dmemRdata));
                end
            end else if (writeEnabled && !m_origin) begin
                model_exec(take, mem);
                if (!mem) m_instret++;
            end
            m_origin = take;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("originPc", originPc, m_origin);
            chk("hold", hold, m_busy);
            chk("dmemReq", dmemReq, m_busy);
            if (m_origin) chk("pcBranch", pcBranch, m_pcb);
            if (m_busy) begin
                chk("dmemWe", dmemWe, m_we);
                chk("dmemAddr", dmemAddr, m_addr);
                chk("dmemBe", dmemBe, m_be);
                if (m_we) chk("dmemWdata", dmemWdata, m_wdata);
            end
`ifdef EXECUTE_INSTRET_EN
            chk("instret", instret, m_instret);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input logic [31:0] pc);
        code = {1'b0, alt, f3, op};
        rd = d; rs1 = s1; rs2 = s2; imm = im; pcIn = pc;
        isLoad = (op == LOAD);
        isBranch = (op == BR || op == JAL || op == JALR);
        writeEnabled = 1'b1;
        tick();
        writeEnabled = 1'b0;
    endtask

    task automatic sw_check(input string name, input logic [4:0] src, input logic [31:0] exp);
        slot(STORE, 3'b010, 1'b0, 5'd0, 5'd0, src, 32'h100, 32'h0);
        chk(name, dmemWdata, exp);
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
    endtask

    task automatic ld(input string name, input logic [4:0] d, input logic [2:0] f3,
                      input logic [31:0] im, input logic [3:0] exp_be, input logic [31:0] rdata);
        slot(LOAD, f3, 1'b0, d, 5'd3, 5'd0, im, 32'h0);
        chk(name, dmemBe, exp_be);
        dmemRdata = rdata;
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rd = '0; rs1 = '0; rs2 = '0; imm = '0; code = '0; isLoad = 0;
        isBranch = 0; writeEnabled = 0; pcIn = '0; dmemRdata = '0; dmemAck = 0;
        tick();
        cmp_on = 1;
        tick();
        chk("rst_pcBranch", pcBranch, 0);
        chk("rst_dmemAddr", dmemAddr, 0);
        chk("rst_dmemWdata", dmemWdata, 0);
        chk("rst_dmemBe", dmemBe, 0);
        chk("rst_dmemWe", dmemWe, 0);
        reset = 1'b0;

        // ADDI/ADD and write to x0
        slot(OPI, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
        slot(OPR, 3'd0, 0, 5'd2, 5'd1, 5'd1, 32'd0, 0);
        slot(OPI, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd7, 0);
        sw_check("x1", 5'd1, 32'd5);
        sw_check("x2", 5'd2, 32'd10);
        sw_check("x0", 5'd0, 32'd0);

        // taken BEQ, then a wrong-path slot that must be dropped
        slot(BR, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd16, 32'h40);
        chk("beq_origin", originPc, 1);
        chk("beq_target", pcBranch, 32'h50);
        slot(OPI, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd99, 32'h44);
        chk("beq_origin_1cyc", originPc, 0);
        sw_check("x1_after_drop", 5'd1, 32'd5);

        // JALR
        slot(OPI, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h101, 0);
        slot(JALR, 3'd0, 0, 5'd5, 5'd1, 5'd0, 32'd2, 32'h20);
        chk("jalr_target", pcBranch, 32'h102);
        tick();
        sw_check("x5_link", 5'd5, 32'h24);

        // LB with a 3-cycle wait, plus a slot presented during hold
        slot(OPI, 3'd0, 0, 5'd3, 5'd0, 5'd0, 32'h80, 0);
        slot(LOAD, 3'd0, 0, 5'd4, 5'd3, 5'd0, 32'd1, 0);
        chk("lb_hold1", hold, 1);
        chk("lb_be", dmemBe, 4'b0010);
        chk("lb_addr", dmemAddr, 32'h81);
        slot(OPI, 3'd0, 0, 5'd8, 5'd0, 5'd0, 32'd1, 0);
        chk("lb_hold2", hold, 1);
        dmemRdata = 32'h0000_F000;
        dmemAck = 1'b1;
        chk("lb_hold3", hold, 1);
        tick();
        dmemAck = 1'b0;
        chk("lb_hold_done", hold, 0);
        sw_check("x4_lb", 5'd4, 32'hFFFF_FFF0);
        sw_check("x8_dropped", 5'd8, 32'd0);

        // stores
        slot(LUI, 3'd0, 0, 5'd6, 5'd0, 5'd0, 32'hDEADC000, 0);
        slot(OPI, 3'd0, 0, 5'd6, 5'd6, 5'd0, 32'hFFFF_FEEF, 0);
        slot(STORE, 3'b010, 0, 5'd0, 5'd3, 5'd6, 32'd4, 0);
        chk("sw_we", dmemWe, 1);
        chk("sw_addr", dmemAddr, 32'h84);
        chk("sw_be", dmemBe, 4'b1111);
        tick();
        chk("sw_wdata", dmemWdata, 32'hDEADBEEF);
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        slot(STORE, 3'b000, 0, 5'd0, 5'd3, 5'd6, 32'd2, 0);
        chk("sb_be", dmemBe, 4'b0100);
        chk("sb_wdata", dmemWdata, 32'hEFEFEFEF);
        dmemAck = 1'b1; tick(); dmemAck = 1'b0;
        slot(STORE, 3'b001, 0, 5'd0, 5'd3, 5'd6, 32'd2, 0);
        chk("sh_be", dmemBe, 4'b1100);
        chk("sh_wdata", dmemWdata, 32'hBEEFBEEF);
        dmemAck = 1'b1; tick(); dmemAck = 1'b0;

        // loads of other widths
        ld("lhu_be", 5'd9, 3'b101, 32'd2, 4'b1100, 32'h8001_0000);
        ld("lh_be", 5'd10, 3'b001, 32'd2, 4'b1100, 32'h8001_0000);
        ld("lw_be", 5'd11, 3'b010, 32'd3, 4'b1111, 32'h1234_5678);
        sw_check("x9_lhu", 5'd9, 32'h0000_8001);
        sw_check("x10_lh", 5'd10, 32'hFFFF_8001);
        sw_check("x11_lw", 5'd11, 32'h1234_5678);

        // ALU coverage
        slot(OPI, 3'd0, 0, 5'd12, 5'd0, 5'd0, 32'hFFFF_FFFD, 0);
        slot(OPR, 3'd2, 0, 5'd13, 5'd12, 5'd1, 0, 0);
        slot(OPR, 3'd3, 0, 5'd14, 5'd12, 5'd1, 0, 0);
        slot(OPI, 3'd5, 1, 5'd15, 5'd12, 5'd0, 32'h401, 0);
        slot(OPI, 3'd5, 0, 5'd16, 5'd12, 5'd0, 32'd4, 0);
        slot(OPR, 3'd0, 1, 5'd17, 5'd1, 5'd12, 0, 0);
        slot(OPR, 3'd4, 0, 5'd18, 5'd12, 5'd1, 0, 0);
        slot(OPR, 3'd1, 0, 5'd19, 5'd1, 5'd12, 0, 0);
        slot(AUIPC, 3'd0, 0, 5'd20, 5'd0, 5'd0, 32'h1000, 32'h200);
        sw_check("slt", 5'd13, 32'd1);
        sw_check("sltu", 5'd14, 32'd0);
        sw_check("srai", 5'd15, 32'hFFFF_FFFE);
        sw_check("srli", 5'd16, 32'h0FFF_FFFF);
        sw_check("sub", 5'd17, 32'h104);
        sw_check("xor", 5'd18, 32'hFFFF_FEFC);
        sw_check("sll", 5'd19, 32'h2000_0000);
        sw_check("auipc", 5'd20, 32'h1200);

        // branch variants and JAL
        slot(BR, 3'd1, 0, 5'd0, 5'd0, 5'd0, 32'd16, 32'h300);
        chk("bne_not_taken", originPc, 0);
        slot(BR, 3'd4, 0, 5'd0, 5'd12, 5'd1, 32'hFFFF_FFF8, 32'h300);
        chk("blt_target", pcBranch, 32'h2F8);
        tick();
        slot(BR, 3'd6, 0, 5'd0, 5'd12, 5'd1, 32'd8, 32'h300);
        chk("bltu_not_taken", originPc, 0);
        slot(JAL, 3'd0, 0, 5'd21, 5'd0, 5'd0, 32'h20, 32'h400);
        chk("jal_target", pcBranch, 32'h420);
        tick();
        sw_check("jal_link", 5'd21, 32'h404);

        // unknown opcode is a NOP
        slot(7'h7F, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd77, 0);
        sw_check("nop_x1", 5'd1, 32'h101);

        // reset during MEM_WAIT, then a late ack
        slot(LOAD, 3'b010, 0, 5'd7, 5'd3, 5'd0, 32'd0, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_wait_req", dmemReq, 0);
        chk("rst_wait_hold", hold, 0);
        reset = 1'b0;
        dmemRdata = 32'h55;
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        chk("late_ack_hold", hold, 0);
        sw_check("x7_after_reset", 5'd7, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
